// File: rtl/config_chain_loader_pkg.sv
// ----------------------------------------------------------------------------
// config_chain_loader_pkg
//   Shared definitions for the configuration chain loader: the state width and
//   the FSM state encodings (IDLE=0, LOAD=1, SHIFT=2, LATCH=3, DONE=4).
// ----------------------------------------------------------------------------
package config_chain_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/cfg_word_serializer.sv
// ----------------------------------------------------------------------------
// cfg_word_serializer
//   IN_W-bit shift register used both as a parallel-in/serial-out stage (the
//   loader reads par_o[0]) and as a serial-in/parallel-out stage (ser_i enters
//   at the MSB on every shift). Tracks how many bits of the current word have
//   been shifted and flags the shift that reaches the per-word limit.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr_i        drop the current word (register and bit count cleared)
//   load_i       capture data_i and restart the per-word bit count
//   data_i       parallel word
//   limit_i      number of bits in the current word (1..IN_W)
//   shift_i      shift right by one, ser_i enters at the MSB
//   ser_i        serial input
//   par_o        register contents
//   last_o       this shift is the final bit of the current word
// ----------------------------------------------------------------------------
module cfg_word_serializer
  import config_chain_loader_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int LIM_W = $clog2(IN_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [IN_W-1:0]  data_i,
  input  logic [LIM_W-1:0] limit_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [IN_W-1:0]  par_o,
  output logic             last_o
);

  logic [IN_W-1:0]  shreg_q, shreg_d;
  logic [LIM_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = {ser_i, shreg_q[IN_W-1:1]};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign par_o  = shreg_q;
  assign last_o = shift_i && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/config_chain_loader.sv
// ----------------------------------------------------------------------------
// config_chain_loader
//   Streams a configuration bitstream into one serial config chain. Words are
//   accepted on a ready/valid port, shifted LSB-first onto shift_in with cen
//   high, and after exactly CHAIN_LEN bits cset pulses once to latch the chain.
//   abort abandons a load without latching.
//
// Build option:
//   CONFIG_LOADER_READBACK_EN  when defined, shift_out is captured MSB-in while
//   cen=1 and returned as rb_data/rb_valid words (final partial word right-
//   justified, pulsed in the LATCH cycle). When undefined, rb_data/rb_valid
//   are tied to 0 and shift_out is ignored.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start, abort       begin a load (IDLE only) / abandon a load
//   cfg_data/valid/ready  config word input handshake
//   cen, shift_in, cset   chain shift enable, serial data, latch pulse
//   shift_out          chain tail (readback)
//   busy, done         load in progress / one-cycle completion pulse
//   rb_data, rb_valid  readback word and its one-cycle strobe
// ----------------------------------------------------------------------------
module config_chain_loader
  import config_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 3072,
  parameter int IN_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [IN_W-1:0] cfg_data,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  output logic            cen,
  output logic            shift_in,
  output logic            cset,
  input  logic            shift_out,
  output logic            busy,
  output logic            done,
  output logic [IN_W-1:0] rb_data,
  output logic            rb_valid
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int LIM_W = $clog2(IN_W + 1);

  state_e           state_q;
  logic             rdy_q, cen_q, cset_q, busy_q, done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LIM_W-1:0] lim_q;

  logic             hs, shift_en, word_last, chain_last;
  logic [IN_W-1:0]  tx_par;
  logic [IN_W-2:0]  unused_tx_par;

  // Bits in the next word: a full word, or whatever is left of the chain.
  function automatic logic [LIM_W-1:0] word_limit(input logic [CNT_W-1:0] sent);
    int rem;
    rem = CHAIN_LEN - int'(sent);
    if (rem >= IN_W) return LIM_W'(IN_W);
    else             return LIM_W'(rem);
  endfunction

  // abort masks the handshake so a word offered in the same cycle is kept.
  assign hs         = rdy_q && cfg_valid && !abort;
  assign shift_en   = cen_q && !abort;
  assign chain_last = (cnt_q == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      cen_q   <= 1'b0;
      cset_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      cset_q <= 1'b0;
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        rdy_q   <= 1'b0;
        cen_q   <= 1'b0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q <= S_LOAD;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          S_LOAD: begin
            if (hs) begin
              state_q <= S_SHIFT;
              rdy_q   <= 1'b0;
              cen_q   <= 1'b1;
              lim_q   <= word_limit(cnt_q);
            end
          end
          S_SHIFT: begin
            cnt_q <= cnt_q + 1'b1;
            if (word_last) begin
              cen_q <= 1'b0;
              if (chain_last) begin
                state_q <= S_LATCH;
                cset_q  <= 1'b1;
              end else begin
                state_q <= S_LOAD;
                rdy_q   <= 1'b1;
              end
            end
          end
          S_LATCH: begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            cen_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  cfg_word_serializer #(
    .IN_W (IN_W),
    .LIM_W(LIM_W)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (abort),
    .load_i (hs),
    .data_i (cfg_data),
    .limit_i(lim_q),
    .shift_i(shift_en),
    .ser_i  (1'b0),
    .par_o  (tx_par),
    .last_o (word_last)
  );

  assign unused_tx_par = tx_par[IN_W-1:1];

  assign cfg_ready = rdy_q && !abort;
  assign cen       = cen_q;
  assign shift_in  = cen_q && tx_par[0];
  assign cset      = cset_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CONFIG_LOADER_READBACK_EN
  logic [IN_W-1:0] rb_par, rb_data_q;
  logic            rb_valid_q;
  logic            unused_rb_last;

  // A short final word sits in the top bits; move it down to bit 0.
  function automatic logic [IN_W-1:0] right_justify(input logic [IN_W-1:0] w,
                                                    input logic [LIM_W-1:0] lim);
    return w >> (IN_W - int'(lim));
  endfunction

  cfg_word_serializer #(
    .IN_W (IN_W),
    .LIM_W(LIM_W)
  ) u_rb (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (abort),
    .load_i (hs),
    .data_i ('0),
    .limit_i(lim_q),
    .shift_i(shift_en),
    .ser_i  (shift_out),
    .par_o  (rb_par),
    .last_o (unused_rb_last)
  );

  // The word is complete including the bit sampled on the last shift, so the
  // strobe lands in the following LOAD (or LATCH) cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= word_last;
      if (word_last) rb_data_q <= right_justify({shift_out, rb_par[IN_W-1:1]}, lim_q);
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_shift_out;
  assign unused_shift_out = shift_out;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule
